dmem_responder: RTL and testbench

Data-memory responder for the fewcore pipeline: the target end of the core's load/store path. It accepts one word-addressed read or write request at a time over a valid/ready handshake, inserts a fixed number of wait states, and returns a response (read data plus error flag) over a second valid/ready handshake. It replaces the zero-latency memData path wherever the core talks to slower memory, and lets the core's stall logic be verified against a realistic target.

---
 rtl/fewcore_pkg.sv | 19 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fewcore_pkg.sv
// Shared types and constants for the fewcore data-memory path.
package fewcore_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_t;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

  // A word access must start on a word boundary.
  function automatic logic misaligned(input logic [1:0] byte_off);
    return |byte_off;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and an unregistered read.
module dmem_array
  import fewcore_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] wstrb,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one request at a time, fixed wait states, registered response.
module dmem_responder
  import fewcore_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t      state;
  logic [CNT_W-1:0] wait_cnt;
  logic             wr_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  logic             access;
  logic             acc_err;
  logic             mem_we;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_rdata;

  assign req_ready = (state == IDLE);

  assign idx     = addr_q[IDX_W+1:2];
  assign acc_err = misaligned(addr_q[1:0]) || ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
  assign access  = (state == BUSY) && (wait_cnt == CNT_W'(1));
  // Gating on BUSY means a reset during the wait drops a pending store.
  assign mem_we  = access && wr_q && !acc_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .wstrb(wstrb_q),
    .idx  (idx),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  // Request capture, wait-state countdown, access and response handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q     <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wstrb_q  <= req_wstrb;
            wait_cnt <= CNT_W'(LATENCY);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt == CNT_W'(1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (wr_q || acc_err) ? '0 : mem_rdata;
            wait_cnt  <= '0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 3 and 1.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  int          sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;

  logic [2:0]  vld;
  logic [2:0]  ready_v;
  logic [2:0]  valid_v;
  logic [2:0]  err_v;
  logic [31:0] rdata_v [3];

  logic        m_ready;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign vld[0] = req_valid && (sel == 0);
  assign vld[1] = req_valid && (sel == 1);
  assign vld[2] = req_valid && (sel == 2);

  assign m_ready = ready_v[sel];
  assign m_valid = valid_v[sel];
  assign m_err   = err_v[sel];
  assign m_rdata = rdata_v[sel];

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(rst_n[0]), .req_valid(vld[0]), .req_ready(ready_v[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(valid_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_v[0]), .rsp_err(err_v[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(rst_n[1]), .req_valid(vld[1]), .req_ready(ready_v[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(valid_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_v[1]), .rsp_err(err_v[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(rst_n[2]), .req_valid(vld[2]), .req_ready(ready_v[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(valid_v[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_v[2]), .rsp_err(err_v[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One complete transaction on the selected DUT with rsp_ready high.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = m_rdata;
    err   = m_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          last;
    int          nacc;

    rst_n     = '0;
    sel       = 0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(m_valid), 64'd0);
    check("rst_rsp_rdata", 64'(m_rdata), 64'd0);
    check("rst_rsp_err",   64'(m_err),   64'd0);
    @(negedge clk);
    rst_n = '1;
    #1;
    check("rst_req_ready", 64'(m_ready), 64'd1);

    // Write then read, LATENCY=2
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("st10_lat",   64'(lat), 64'd2);
    check("st10_err",   64'(er),  64'd0);
    check("st10_rdata", 64'(rd),  64'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_lat",   64'(lat), 64'd2);
    check("ld10_err",   64'(er),  64'd0);
    check("ld10_rdata", 64'(rd),  64'hDEADBEEF);

    // Byte lanes
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("lanes_rdata", 64'(rd), 64'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check("strb0_err", 64'(er), 64'd0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("strb0_rdata", 64'(rd), 64'h11BB33DD);

    // Errors
    do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    check("mis_err",   64'(er), 64'd1);
    check("mis_rdata", 64'(rd), 64'd0);
    do_req(1'b1, 32'h0, 32'h0BADCAFE, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("oor_err", 64'(er), 64'd1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("oor_word0", 64'(rd), 64'h0BADCAFE);
    check("word0_err", 64'(er), 64'd0);
    do_req(1'b1, 32'h3FC, 32'h5A5A1234, 4'hF, rd, er, lat);
    check("last_st_err", 64'(er), 64'd0);
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    check("last_ld_rdata", 64'(rd), 64'h5A5A1234);

    // Back-pressure with a second request held during RESP
    rsp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 32'h20;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_lat", 64'(n), 64'd2);
    req_addr  = 32'h10;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", {30'd0, m_valid, m_ready, m_rdata}, {30'd0, 1'b1, 1'b0, 32'h11BB33DD});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {62'd0, m_valid, m_ready}, {62'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    check("bp_second_accepted", 64'(m_ready), 64'd0);
    req_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp2_lat",   64'(n),       64'd2);
    check("bp2_rdata", 64'(m_rdata), 64'hDEADBEEF);
    @(posedge clk);
    #1;

    // Reset during BUSY, LATENCY=3
    sel = 1;
    do_req(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
    check("l3_st_lat", 64'(lat), 64'd3);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hCAFEF00D;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("l3_accepted", 64'(m_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("l3_in_reset", {62'd0, m_valid, m_ready}, {62'd0, 1'b0, 1'b1});
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    check("l3_after_rel", {62'd0, m_valid, m_ready}, {62'd0, 1'b0, 1'b1});
    do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    check("l3_word30", 64'(rd), 64'h12345678);

    // Throughput, LATENCY=1
    sel = 2;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("l1_st_lat", 64'(lat), 64'd1);
    @(negedge clk);
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    last = -1;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_ready) begin
        if (last >= 0) check("tp_gap", 64'(c - last), 64'd3);
        last = c;
        nacc++;
      end
      if (m_valid) check("tp_rdata", 64'(m_rdata), 64'hDEADBEEF);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("tp_count", 64'(nacc), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
